cpu_bus_decoder: RTL
====================

# cpu_bus_decoder

Single-master, four-slave bus decoder placed directly downstream of the processor core bus port. It accepts Avalon-style read/write requests from the CPU and decodes the address against four base/mask regions. It forwards each transfer to exactly one slave and returns registered read data and a response code to the CPU. Unmapped addresses and slaves that stall past a timeout terminate with an error response, so the CPU never hangs.

## Interface
- TIMEOUT_CYCLES, 256: maximum consecutive slave wait cycles before abort; 0 disables the timeout; legal range 0..65535.
- S0_BASE, 32'h0000_0000: slave 0 base address. S0_MASK, 32'hFFFF_0000: slave 0 match mask.
- S1_BASE, 32'h1000_0000 / S1_MASK, 32'hFFFF_F000: slave 1 region.
- S2_BASE, 32'h2000_0000 / S2_MASK, 32'hFFFF_F000: slave 2 region.
- S3_BASE, 32'h3000_0000 / S3_MASK, 32'hFFFF_F000: slave 3 region.

Ports:
- clk  input  1  clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- m_addr  input  32  CPU address.
- m_read  input  1  CPU read request.
- m_write  input  1  CPU write request.
- m_writedata  input  32  CPU write data.
- m_byteenable  input  4  CPU byte enables.
- m_readdata  output  32  read data returned to the CPU.
- m_response  output  2  response code: 00 OKAY, 10 SLVERR (timeout), 11 DECERR (unmapped).
- m_waitrequest  output  1  low for exactly one cycle per completed transfer.
- s_addr  output  32  latched address, shared by all slaves.
- s_writedata  output  32  latched write data, shared.
- s_byteenable  output  4  latched byte enables, shared.
- s_read  output  4  one-hot read strobe; bit i drives slave i.
- s_write  output  4  one-hot write strobe.
- s_readdata  input  128  slave i read data in bits [32i+31:32i].
- s_response  input  8  slave i response in bits [2i+1:2i].
- s_waitrequest  input  4  slave i wait request.

## Operation
- FSM states:
  - IDLE
  - ACCESS
  - RESP
- IDLE behaviour:
  - Idles until m_read or m_write is high.
  - On a request, registers m_addr, m_writedata, m_byteenable, the direction, and the slave index.
  - If both m_read and m_write are high, the transfer is a write.
- Decode rule:
  - Slave i hits when (m_addr & Si_MASK) == Si_BASE.
  - If several regions overlap, the lowest index wins.
- IDLE exits:
  - Hit: go to ACCESS; the timeout counter clears to 0.
  - No hit: go to RESP with response 11 and readdata 0; no slave strobe is asserted.
- ACCESS:
  - s_read[sel] or s_write[sel] is held high, driven from registers; all other strobe bits stay 0.
  - If s_waitrequest[sel] is low: capture s_readdata[sel] (forced to 0 on writes) and s_response[sel]; go to RESP.
  - Otherwise the counter increments.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: drop the strobe, go to RESP with response 10 and readdata 0.
- RESP:
  - m_waitrequest is 0 for this single cycle, with the registered m_readdata and m_response.
  - Always returns to IDLE next cycle.
- The counter is 16 bits and saturates; it never wraps.
- Master requests arriving while in ACCESS or RESP are not sampled. The master must hold its request until it sees m_waitrequest low.

## Timing
- Reset values:
  - state IDLE; counter 0.
  - m_waitrequest 1; m_readdata 0; m_response 00.
  - s_read 0; s_write 0.
  - s_addr, s_writedata, s_byteenable 0.
- Reset asserted mid-transfer: on that same edge, all strobes drop, the FSM returns to IDLE, and no response is issued.
- m_waitrequest is high in IDLE and ACCESS.
- Latency:
  - Request sampled at edge 0; strobe high in cycle 1.
  - Zero-wait slave: RESP in cycle 2, i.e. 2 cycles from request to completion. Each slave wait cycle adds 1.
  - Unmapped address: completes in cycle 1.
  - Timeout: strobe is high for TIMEOUT_CYCLES+1 cycles, then RESP.
- Back-to-back: the earliest next capture is the cycle after RESP. A master request still high in the IDLE cycle after RESP is treated as a new transfer.
- All outputs are registered; there is no combinational path from any s_* input to any m_* output.

## Test plan
- Read from 0x0000_0040, slave 0 with zero wait returning 0xCAFE_F00D/00 -> s_read=0001 for one cycle (cycle 1); m_waitrequest low in cycle 2 with readdata 0xCAFE_F00D, response 00.
- Write to 0x2000_0008, data 0x1234_5678, byteenable 0011, slave 2 waits 3 cycles -> s_write=0100 with latched data for 4 cycles; m_waitrequest low once in cycle 5; readdata 0, response 00.
- Read from 0x5000_0000 (unmapped) -> no strobe; m_waitrequest low in cycle 1, readdata 0, response 11.
- TIMEOUT_CYCLES=4, slave 1 holds waitrequest high -> s_read=0010 for 5 cycles then 0; response 10, readdata 0; the next read to slave 0 completes normally.
- Reset pulsed in cycle 2 of a stalled slave 3 write -> s_write=0000 and m_waitrequest=1 after that edge; a subsequent request completes with no stale response.
- Back-to-back reads to slaves 0 then 1, master re-asserting m_read the cycle after completion -> the second transfer is captured, strobes are one-hot with no overlap, and exactly two completions occur.

Source files
------------

// File: rtl/cpu_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_decoder
// Description : Single-master, four-slave bus decoder. Takes Avalon-style
//               read/write requests from the CPU and decodes the address
//               against four base/mask regions. Each transfer goes to exactly
//               one slave, and the CPU gets back registered read data and a
//               response code. Unmapped addresses and stalled slaves end with
//               an error response, so the CPU never hangs.
//
// Ports       : clk, rst              clock, synchronous active-high reset
//               m_addr/m_read/m_write/m_writedata/m_byteenable
//                                     CPU request inputs
//               m_readdata/m_response/m_waitrequest
//                                     registered CPU completion outputs
//               s_addr/s_writedata/s_byteenable
//                                     latched request, shared by all slaves
//               s_read/s_write        one-hot strobes (bit i -> slave i)
//               s_readdata/s_response/s_waitrequest
//                                     packed slave returns (lane i = slave i)
//
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] S0_BASE        = 32'h0000_0000,
    parameter logic [31:0] S0_MASK        = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE        = 32'h1000_0000,
    parameter logic [31:0] S1_MASK        = 32'hFFFF_F000,
    parameter logic [31:0] S2_BASE        = 32'h2000_0000,
    parameter logic [31:0] S2_MASK        = 32'hFFFF_F000,
    parameter logic [31:0] S3_BASE        = 32'h3000_0000,
    parameter logic [31:0] S3_MASK        = 32'hFFFF_F000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  m_addr,
    input  logic         m_read,
    input  logic         m_write,
    input  logic [31:0]  m_writedata,
    input  logic [3:0]   m_byteenable,
    output logic [31:0]  m_readdata,
    output logic [1:0]   m_response,
    output logic         m_waitrequest,
    output logic [31:0]  s_addr,
    output logic [31:0]  s_writedata,
    output logic [3:0]   s_byteenable,
    output logic [3:0]   s_read,
    output logic [3:0]   s_write,
    input  logic [127:0] s_readdata,
    input  logic [7:0]   s_response,
    input  logic [3:0]   s_waitrequest
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;

    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    localparam logic [15:0] c_timeout    = TIMEOUT_CYCLES[15:0];
    localparam logic        c_timeout_en = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] c_count_max  = 16'hFFFF;

    // Region tables packed so the hit generator can index them by slave number.
    localparam logic [127:0] c_bases = {S3_BASE, S2_BASE, S1_BASE, S0_BASE};
    localparam logic [127:0] c_masks = {S3_MASK, S2_MASK, S1_MASK, S0_MASK};

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [15:0] r_count;
    logic [1:0]  r_sel;
    logic        r_is_write;
    logic [31:0] r_addr;
    logic [31:0] r_writedata;
    logic [3:0]  r_byteenable;
    logic [3:0]  r_s_read;
    logic [3:0]  r_s_write;
    logic [31:0] r_readdata;
    logic [1:0]  r_response;
    logic        r_waitrequest;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [3:0]  w_hit;
    logic        w_hit_any;
    logic [1:0]  w_sel;
    logic [3:0]  w_onehot;
    logic        w_req;
    logic        w_sel_wait;
    logic [31:0] w_sel_readdata;
    logic [1:0]  w_sel_response;
    logic [1:0]  w_state_next;
    logic        w_capture;
    logic        w_done;
    logic        w_abort;

    // ------------------------------------------------------------------------
    // Address decode: one comparator per region, lowest index wins on overlap
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hit
            assign w_hit[gi] = ((m_addr & c_masks[32*gi +: 32]) == c_bases[32*gi +: 32]);
        end
    endgenerate

    always_comb begin
        w_sel = 2'd0;
        if (w_hit[0]) begin
            w_sel = 2'd0;
        end else if (w_hit[1]) begin
            w_sel = 2'd1;
        end else if (w_hit[2]) begin
            w_sel = 2'd2;
        end else if (w_hit[3]) begin
            w_sel = 2'd3;
        end
    end

    assign w_hit_any = |w_hit;
    assign w_onehot  = 4'b0001 << w_sel;
    assign w_req     = m_read | m_write;

    // Returns from the latched target slave only. These feed registers and
    // never reach the m_* outputs combinationally.
    assign w_sel_wait     = s_waitrequest[r_sel];
    assign w_sel_readdata = s_readdata[{r_sel, 5'd0} +: 32];
    assign w_sel_response = s_response[{r_sel, 1'b0} +: 2];

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_req) begin
                    w_capture    = 1'b1;
                    w_state_next = w_hit_any ? c_st_access : c_st_resp;
                end
            end
            c_st_access: begin
                // A slave that completes in the same cycle the timeout would
                // fire still wins: the transfer really did finish.
                if (!w_sel_wait) begin
                    w_done       = 1'b1;
                    w_state_next = c_st_resp;
                end else if (c_timeout_en && (r_count == c_timeout)) begin
                    w_abort      = 1'b1;
                    w_state_next = c_st_resp;
                end
            end
            c_st_resp: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= 16'd0;
            r_sel         <= 2'd0;
            r_is_write    <= 1'b0;
            r_addr        <= 32'd0;
            r_writedata   <= 32'd0;
            r_byteenable  <= 4'd0;
            r_s_read      <= 4'd0;
            r_s_write     <= 4'd0;
            r_readdata    <= 32'd0;
            r_response    <= 2'b00;
            r_waitrequest <= 1'b1;
        end else begin
            // The completion handshake is the only cycle spent in RESP.
            r_waitrequest <= (w_state_next != c_st_resp);

            if (w_capture) begin
                r_addr       <= m_addr;
                r_writedata  <= m_writedata;
                r_byteenable <= m_byteenable;
                r_is_write   <= m_write;
                r_sel        <= w_sel;
                r_count      <= 16'd0;
                if (w_hit_any) begin
                    r_s_read  <= m_write ? 4'd0 : w_onehot;
                    r_s_write <= m_write ? w_onehot : 4'd0;
                end else begin
                    r_readdata <= 32'd0;
                    r_response <= c_resp_decerr;
                end
            end else if (w_done) begin
                r_s_read   <= 4'd0;
                r_s_write  <= 4'd0;
                r_readdata <= r_is_write ? 32'd0 : w_sel_readdata;
                r_response <= w_sel_response;
            end else if (w_abort) begin
                r_s_read   <= 4'd0;
                r_s_write  <= 4'd0;
                r_readdata <= 32'd0;
                r_response <= c_resp_slverr;
            end else if ((r_state == c_st_access) && (r_count != c_count_max)) begin
                // Saturating wait counter; a disabled timeout parks it at max.
                r_count <= r_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign m_readdata    = r_readdata;
    assign m_response    = r_response;
    assign m_waitrequest = r_waitrequest;
    assign s_addr        = r_addr;
    assign s_writedata   = r_writedata;
    assign s_byteenable  = r_byteenable;
    assign s_read        = r_s_read;
    assign s_write       = r_s_write;

endmodule
`default_nettype wire
